seq_divider_restoring: RTL and testbench



---
 rtl/seq_divider_restoring_pkg.sv | 19 +
 rtl/seq_divider_restoring_div_sub_step.sv | 20 ++
 rtl/seq_divider_restoring.sv | 123 ++++++++++++
 tb/tb_seq_divider_restoring.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_restoring_pkg.sv
// Shared types and default widths for the restoring sequential divider.
package seq_divider_restoring_pkg;

    localparam int unsigned DEF_DW = 8;
    localparam int unsigned DEF_SW = 4;

    function automatic int unsigned cnt_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

    localparam int unsigned CW = cnt_width(DEF_DW);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StZero
    } state_e;

endpackage

// File: rtl/seq_divider_restoring_div_sub_step.sv
// One restoring division step: trial-subtract the divisor from the shifted partial remainder.
module seq_divider_restoring_div_sub_step #(
    parameter int unsigned SW = 4
) (
    input  logic [SW:0]   r_shift,
    input  logic [SW-1:0] divisor,
    output logic [SW-1:0] r_next,
    output logic          q_bit
);

    logic [SW:0] trial;

    always_comb begin
        trial = r_shift - {1'b0, divisor};
        q_bit = ~trial[SW];
        // Either result is below the divisor, so its top bit is always zero.
        r_next = q_bit ? trial[SW-1:0] : r_shift[SW-1:0];
    end

endmodule

// File: rtl/seq_divider_restoring.sv
// Iterative restoring divider: DW-bit dividend by SW-bit divisor, one quotient bit per clock.
module seq_divider_restoring
    import seq_divider_restoring_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned SW = DEF_SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          dz,
    output logic [DW-1:0] quotient,
    output logic [SW-1:0] remainder
);

    localparam int unsigned CntW = cnt_width(DW);
    localparam logic [CntW-1:0] LastCnt = CntW'(DW - 1);

    state_e        state_q, state_d;
    logic [SW-1:0] r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] divisor_q, divisor_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [SW-1:0] rem_q, rem_d;

    logic [SW:0]   r_shift;
    logic [SW-1:0] r_next;
    logic          q_bit;
    logic [DW-1:0] q_shift;

    assign r_shift = {r_q, q_q[DW-1]};
    assign q_shift = {q_q[DW-2:0], q_bit};

    seq_divider_restoring_div_sub_step #(
        .SW(SW)
    ) u_sub_step (
        .r_shift(r_shift),
        .divisor(divisor_q),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    divisor_d = divisor;
                    q_d       = dividend;
                    r_d       = '0;
                    cnt_d     = '0;
                    state_d   = (divisor == '0) ? StZero : StRun;
                end
            end
            StRun: begin
                r_d   = r_next;
                q_d   = q_shift;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    dz_d    = 1'b0;
                    quot_d  = q_shift;
                    rem_d   = r_next;
                end
            end
            StZero: begin
                state_d = StIdle;
                done_d  = 1'b1;
                dz_d    = 1'b1;
                quot_d  = '1;
                rem_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            divisor_q <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign dz        = dz_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_seq_divider_restoring.sv
// Self-checking bench for seq_divider_restoring against an arithmetic reference model.
module tb_seq_divider_restoring;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic       dz;
    logic [7:0] quotient;
    logic [3:0] remainder;

    int n_pass  = 0;
    int n_total = 0;

    seq_divider_restoring dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .dz       (dz),
        .quotient (quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive a request so it is sampled at the next rising edge; returns #1 after that edge.
    task automatic start_op(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!done && busy) busy_cnt++;
        end
    endtask

    task automatic run_div(input logic [7:0] a, input logic [3:0] b, input string tag);
        int cyc, bcnt, lat;
        logic [7:0] eq;
        logic [3:0] er;
        lat = (b == 0) ? 1 : 8;
        eq  = (b == 0) ? 8'hFF : 8'(a / b);
        er  = (b == 0) ? 4'd0 : 4'(a % b);
        start_op(a, b);
        check({tag, ".busy_e0"}, busy, 1);
        wait_done(cyc, bcnt);
        check({tag, ".latency"}, cyc, lat);
        check({tag, ".busy_cycles"}, bcnt, lat);
        check({tag, ".quotient"}, quotient, eq);
        check({tag, ".remainder"}, remainder, er);
        check({tag, ".dz"}, dz, (b == 0) ? 1 : 0);
        check({tag, ".busy_at_done"}, busy, 0);
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".quot_held"}, quotient, eq);
        check({tag, ".rem_held"}, remainder, er);
    endtask

    initial begin
        int cyc, bcnt, pre;
        logic [7:0] ra;
        logic [3:0] rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.dz", dz, 0);
        check("reset.quotient", quotient, 0);
        check("reset.remainder", remainder, 0);
        rst = 1'b0;

        run_div(8'd143, 4'd11, "d143_11");
        run_div(8'd200, 4'd7, "d200_7");
        run_div(8'd255, 4'd1, "d255_1");
        run_div(8'd7, 4'd9, "d7_9");
        run_div(8'd0, 4'd5, "d0_5");
        run_div(8'd100, 4'd0, "d100_0");
        run_div(8'd60, 4'd6, "dz_clear");

        // A start during an active division must be ignored.
        start_op(8'd225, 4'd15);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        dividend = 8'd50;
        divisor  = 4'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pre   = 3;
        wait_done(cyc, bcnt);
        check("ignore.latency", pre + cyc, 8);
        check("ignore.quotient", quotient, 15);
        check("ignore.remainder", remainder, 0);
        @(posedge clk);
        #1;
        check("ignore.no_restart", busy, 0);

        // Back-to-back: new start in the done cycle.
        start_op(8'd143, 4'd11);
        wait_done(cyc, bcnt);
        check("b2b.first_done", done, 1);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b.accepted", busy, 1);
        check("b2b.quot_held", quotient, 13);
        check("b2b.rem_held", remainder, 0);
        wait_done(cyc, bcnt);
        check("b2b.latency", cyc, 8);
        check("b2b.quotient", quotient, 28);
        check("b2b.remainder", remainder, 4);

        // Reset in the middle of a division.
        start_op(8'd143, 4'd11);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort.no_early_done", done, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.dz", dz, 0);
        check("abort.quotient", quotient, 0);
        check("abort.remainder", remainder, 0);
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("abort.no_done", done, 0);
        end
        run_div(8'd60, 4'd6, "after_abort");

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 4'($urandom_range(0, 15));
            run_div(ra, rb, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
